// File: rtl/instruction_fetch_stage_pkg.sv
// Shared MIPS datapath definitions used by the instruction fetch stage.
//   NOP_INSTR        : encoding of sll $0,$0,0, loaded into IF/ID as a bubble
//   DEFAULT_RESET_PC : default PC value loaded on reset
//   PC_INCREMENT     : sequential fetch stride in bytes
package instruction_fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INCREMENT     = 32'd4;

    // Clear the byte-offset bits so a loaded PC is always word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_program_counter.sv
// Program counter register for the fetch stage.
// Ports:
//   Clk        in  rising-edge clock
//   Reset      in  synchronous active-low reset, loads RESET_PC
//   Load       in  load LoadValue (word aligned); overrides Stall
//   LoadValue  in  32-bit redirect target byte address
//   Stall      in  hold the current PC
//   PC         out current PC (register output)
module instruction_fetch_stage_program_counter
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Load,
    input  logic [31:0] LoadValue,
    input  logic        Stall,
    output logic [31:0] PC
);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            PC <= RESET_PC;
        end else if (Load) begin
            PC <= word_align(LoadValue);
        end else if (!Stall) begin
            // 32-bit add wraps naturally: 32'hFFFF_FFFC + 4 = 0
            PC <= PC + PC_INCREMENT;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage of the pipelined MIPS datapath.
// Holds the PC, drives the instruction memory address and registers the
// returned instruction together with PC+4 into the IF/ID pipeline register.
// Ports:
//   Clk               in  rising-edge clock
//   Reset             in  synchronous active-low reset
//   Stall             in  hold PC and IF/ID contents
//   Flush             in  load a bubble into IF/ID
//   BranchTaken       in  redirect PC to BranchTarget (beats Jump)
//   BranchTarget      in  branch destination byte address
//   Jump              in  redirect PC to JumpTarget
//   JumpTarget        in  jump destination byte address
//   InstrIn           in  instruction memory read data for PCOut
//   PCOut             out current PC, instruction memory address
//   IFID_Instruction  out registered instruction
//   IFID_PCPlus4      out registered PC+4 of that instruction
//   IFID_Valid        out 1 = real instruction, 0 = bubble
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] InstrIn,
    output logic [31:0] PCOut,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid
);

    logic        redirect;
    logic [31:0] redirect_target;

    // Branch belongs to the older instruction, so it wins over Jump.
    always_comb begin
        redirect        = BranchTaken | Jump;
        redirect_target = BranchTaken ? BranchTarget : JumpTarget;
    end

    instruction_fetch_stage_program_counter #(
        .RESET_PC (RESET_PC)
    ) u_program_counter (
        .Clk       (Clk),
        .Reset     (Reset),
        .Load      (redirect),
        .LoadValue (redirect_target),
        .Stall     (Stall),
        .PC        (PCOut)
    );

    // IF/ID register: Flush beats Stall so a bubble replaces a stalled slot.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            IFID_Instruction <= NOP_INSTR;
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
        end else if (Flush) begin
            IFID_Instruction <= NOP_INSTR;
            IFID_PCPlus4     <= '0;
            IFID_Valid       <= 1'b0;
        end else if (!Stall) begin
            IFID_Instruction <= InstrIn;
            IFID_PCPlus4     <= PCOut + PC_INCREMENT;
            IFID_Valid       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed self-checking bench for instruction_fetch_stage.
// A combinational memory model returns word i = i*3 at Address[8:2].
module tb_instruction_fetch_stage;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Flush;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic [31:0] InstrIn;
    logic [31:0] PCOut;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;

    int unsigned asserts_done = 0;
    int unsigned errors       = 0;

    instruction_fetch_stage #(
        .RESET_PC (32'h0000_0000)
    ) dut (
        .Clk              (Clk),
        .Reset            (Reset),
        .Stall            (Stall),
        .Flush            (Flush),
        .BranchTaken      (BranchTaken),
        .BranchTarget     (BranchTarget),
        .Jump             (Jump),
        .JumpTarget       (JumpTarget),
        .InstrIn          (InstrIn),
        .PCOut            (PCOut),
        .IFID_Instruction (IFID_Instruction),
        .IFID_PCPlus4     (IFID_PCPlus4),
        .IFID_Valid       (IFID_Valid)
    );

    always #5 Clk = ~Clk;

    logic [6:0] mem_index;
    assign mem_index = PCOut[8:2];
    assign InstrIn   = 32'(mem_index) * 32'd3;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        asserts_done++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance one edge and settle away from it before checking.
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                             input logic [31:0] pc4, input logic valid);
        check_eq({tag, " pc"},    PCOut, pc);
        check_eq({tag, " instr"}, IFID_Instruction, instr);
        check_eq({tag, " pc4"},   IFID_PCPlus4, pc4);
        check_eq({tag, " valid"}, {31'b0, IFID_Valid}, {31'b0, valid});
    endtask

    initial begin
        Reset = 1'b0; Stall = 1'b0; Flush = 1'b0;
        BranchTaken = 1'b0; BranchTarget = '0;
        Jump = 1'b0; JumpTarget = '0;

        tick(); tick();
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0);

        Reset = 1'b1;
        tick(); check_all("seq0", 32'h04, 32'd0, 32'h04, 1'b1);
        tick(); check_all("seq1", 32'h08, 32'd3, 32'h08, 1'b1);
        tick(); check_all("seq2", 32'h0C, 32'd6, 32'h0C, 1'b1);
        tick(); check_all("seq3", 32'h10, 32'd9, 32'h10, 1'b1);

        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check_all("stall", 32'h10, 32'd9, 32'h10, 1'b1);
        end
        Stall = 1'b0;
        tick(); check_all("unstall", 32'h14, 32'd12, 32'h14, 1'b1);

        BranchTaken = 1'b1; BranchTarget = 32'h40; Flush = 1'b1;
        tick(); check_all("br_flush", 32'h40, 32'h0, 32'h0, 1'b0);
        BranchTaken = 1'b0; Flush = 1'b0;
        tick(); check_all("br_fetch", 32'h44, 32'd48, 32'h44, 1'b1);

        BranchTaken = 1'b1; BranchTarget = 32'h40;
        Jump = 1'b1; JumpTarget = 32'h80; Stall = 1'b1;
        tick(); check_all("br_vs_jmp", 32'h40, 32'd48, 32'h44, 1'b1);

        Jump = 1'b0; Stall = 1'b0; BranchTarget = 32'h43;
        tick(); check_all("align", 32'h40, 32'd48, 32'h44, 1'b1);

        BranchTaken = 1'b0; Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
        tick(); check_all("jmp_top", 32'hFFFF_FFFC, 32'd48, 32'h44, 1'b1);
        Jump = 1'b0;
        tick(); check_all("wrap", 32'h0, 32'd381, 32'h0, 1'b1);
        tick(); check_all("post_wrap", 32'h04, 32'd0, 32'h04, 1'b1);

        Reset = 1'b0; Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h80;
        tick(); check_all("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0);

        Reset = 1'b1; Stall = 1'b0; Jump = 1'b0;
        tick(); check_all("rerun", 32'h04, 32'd0, 32'h04, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts_done, errors);
        $finish;
    end

endmodule
